// File: rtl/dec2int.sv
`default_nettype none
// ============================================================================
// Module      : dec2int
// Description : Serial decimal-to-binary converter. Takes a sign flag and a
//               most-significant-first stream of BCD digits, accumulates
//               acc = acc*10 + digit, and emits a saturating signed
//               WIDTH-bit two's-complement result with overflow and error
//               flags.
// Ports       : clk        - clock, rising edge
//               rstn       - asynchronous active-low reset
//               clear      - synchronous abort, returns to IDLE
//               in_valid   - digit beat valid
//               in_ready   - converter can accept a digit beat
//               in_digit   - BCD digit 0..9
//               in_neg     - sign, sampled on the first beat of a frame
//               in_last    - final digit of the frame
//               out_valid  - result available
//               out_ready  - consumer accepts the result
//               out_data   - converted signed integer
//               out_ovf    - magnitude exceeded range, out_data saturated
//               out_err    - bad digit or frame longer than MAX_DIGITS
// Revision    : 1.0 - initial release
// ============================================================================
module dec2int #(
  parameter int WIDTH      = 32,
  parameter int MAX_DIGITS = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_digit,
  input  logic             in_neg,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             out_err
);

  localparam int C_CW = $clog2(MAX_DIGITS + 1);
  localparam int C_AW = WIDTH + 1;   // accumulator holds magnitudes up to 2^(WIDTH-1)
  localparam int C_PW = WIDTH + 5;   // room for acc*10 + 9 before the limit check

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state, w_state_n;
  logic [C_AW-1:0]   r_acc, w_acc_n;
  logic [C_CW-1:0]   r_cnt, w_cnt_n;
  logic              r_neg, w_neg_n;
  logic              r_ovf, w_ovf_n;
  logic              r_err, w_err_n;
  logic              r_live;
  logic              r_out_valid, w_out_valid_n;
  logic [WIDTH-1:0]  r_out_data, w_out_data_n;
  logic              r_out_ovf, w_out_ovf_n;
  logic              r_out_err, w_out_err_n;

  logic              w_beat;
  logic              w_first;
  logic              w_full;
  logic              w_bad;
  logic [3:0]        w_dig;
  logic              w_beat_neg;
  logic [C_PW-1:0]   w_lim;
  logic [C_PW-1:0]   w_wide_acc;
  logic [C_PW-1:0]   w_base;
  logic [C_PW-1:0]   w_sum;
  logic              w_over;
  logic [C_AW-1:0]   w_acc_sat;
  logic [WIDTH-1:0]  w_twos;

  // in_ready stays low until the first clock after reset release.
  assign in_ready  = r_live && (r_state != S_DONE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ovf   = r_out_ovf;
  assign out_err   = r_out_err;

  assign w_beat     = in_valid && in_ready;
  assign w_first    = (r_state == S_IDLE);
  assign w_full     = (r_cnt == C_CW'(MAX_DIGITS));
  assign w_bad      = (in_digit > 4'd9);
  assign w_dig      = w_bad ? 4'd0 : in_digit;
  assign w_beat_neg = w_first ? in_neg : r_neg;

  // Negative numbers may reach one further than positive ones.
  assign w_lim = w_beat_neg ? (C_PW'(1) << (WIDTH - 1))
                            : ((C_PW'(1) << (WIDTH - 1)) - C_PW'(1));

  // The first digit of a frame starts from zero instead of the stale acc.
  assign w_wide_acc = C_PW'(r_acc);
  assign w_base     = w_first ? '0 : ((w_wide_acc << 3) + (w_wide_acc << 1));
  assign w_sum      = w_base + C_PW'(w_dig);
  assign w_over     = (w_sum > w_lim);
  assign w_acc_sat  = w_over ? w_lim[C_AW-1:0] : w_sum[C_AW-1:0];

  assign w_twos = ~w_acc_n[WIDTH-1:0] + WIDTH'(1);

  always_comb begin
    w_state_n     = r_state;
    w_acc_n       = r_acc;
    w_cnt_n       = r_cnt;
    w_neg_n       = r_neg;
    w_ovf_n       = r_ovf;
    w_err_n       = r_err;
    w_out_valid_n = r_out_valid;
    w_out_data_n  = r_out_data;
    w_out_ovf_n   = r_out_ovf;
    w_out_err_n   = r_out_err;

    case (r_state)
      S_IDLE, S_ACCUM: begin
        if (w_beat) begin
          if (!w_first && w_full) begin
            // Over-long frame: flag it, drop the digit, hold the count.
            w_err_n = 1'b1;
          end else begin
            w_acc_n = w_acc_sat;
            w_cnt_n = r_cnt + C_CW'(1);
            w_neg_n = w_beat_neg;
            w_ovf_n = r_ovf | w_over;
            w_err_n = r_err | w_bad;
          end
          if (in_last) begin
            w_state_n     = S_DONE;
            w_out_valid_n = 1'b1;
            w_out_data_n  = w_neg_n ? w_twos : w_acc_n[WIDTH-1:0];
            w_out_ovf_n   = w_ovf_n;
            w_out_err_n   = w_err_n;
          end else begin
            w_state_n = S_ACCUM;
          end
        end
      end
      S_DONE: begin
        if (r_out_valid && out_ready) begin
          w_state_n     = S_IDLE;
          w_acc_n       = '0;
          w_cnt_n       = '0;
          w_neg_n       = 1'b0;
          w_ovf_n       = 1'b0;
          w_err_n       = 1'b0;
          w_out_valid_n = 1'b0;
          w_out_data_n  = '0;
          w_out_ovf_n   = 1'b0;
          w_out_err_n   = 1'b0;
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase

    // Abort wins over any beat or handshake in the same cycle.
    if (clear) begin
      w_state_n     = S_IDLE;
      w_acc_n       = '0;
      w_cnt_n       = '0;
      w_neg_n       = 1'b0;
      w_ovf_n       = 1'b0;
      w_err_n       = 1'b0;
      w_out_valid_n = 1'b0;
      w_out_data_n  = '0;
      w_out_ovf_n   = 1'b0;
      w_out_err_n   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_neg       <= 1'b0;
      r_ovf       <= 1'b0;
      r_err       <= 1'b0;
      r_live      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
      r_out_err   <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_acc       <= w_acc_n;
      r_cnt       <= w_cnt_n;
      r_neg       <= w_neg_n;
      r_ovf       <= w_ovf_n;
      r_err       <= w_err_n;
      r_live      <= 1'b1;
      r_out_valid <= w_out_valid_n;
      r_out_data  <= w_out_data_n;
      r_out_ovf   <= w_out_ovf_n;
      r_out_err   <= w_out_err_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dec2int.sv
`default_nettype none
// ============================================================================
// Module      : tb_dec2int
// Description : Directed self-checking bench for dec2int (WIDTH=32,
//               MAX_DIGITS=16). Frames are given as digit strings; a '<'
//               character encodes the illegal digit 0xC.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dec2int;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   in_digit = 4'd0;
  logic         in_neg = 1'b0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic         out_ovf;
  logic         out_err;

  int n_cmp = 0;
  int n_bad = 0;

  dec2int #(.WIDTH(W), .MAX_DIGITS(16)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_digit  (in_digit),
    .in_neg    (in_neg),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One beat per cycle; in_neg is inverted on later beats so only the
  // first-beat sample can give the right sign.
  task automatic send(input logic neg, input string s);
    for (int i = 0; i < s.len(); i++) begin
      chk("beat_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_digit = 4'(s[i] - 8'h30);
      in_neg   = (i == 0) ? neg : ~neg;
      in_last  = (i == s.len() - 1);
      step();
      if (i != s.len() - 1) chk("mid_frame_valid", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_neg   = 1'b0;
  endtask

  // Called one cycle after the last beat; consumes the result with out_ready=1.
  task automatic result(input string tag, input logic [W-1:0] d, input logic ovf, input logic err);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_ovf"}, 32'(out_ovf), 32'(ovf));
    chk({tag, "_err"}, 32'(out_err), 32'(err));
    chk({tag, "_busy"}, 32'(in_ready), 32'd0);
    step();
    chk({tag, "_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    rstn = 1'b1;
    step();
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Basic frame and latency: result visible the cycle after the 3rd beat
    send(1'b0, "123");
    result("d123", 32'd123, 1'b0, 1'b0);

    send(1'b1, "123");
    result("m123", 32'hFFFF_FF85, 1'b0, 1'b0);

    send(1'b1, "0");
    result("neg0", 32'd0, 1'b0, 1'b0);

    send(1'b1, "2147483648");
    result("minint", 32'h8000_0000, 1'b0, 1'b0);

    send(1'b0, "2147483648");
    result("pos2p31", 32'h7FFF_FFFF, 1'b1, 1'b0);

    send(1'b0, "2147483647");
    result("maxint", 32'h7FFF_FFFF, 1'b0, 1'b0);

    send(1'b0, "99999999999");
    result("nines", 32'h7FFF_FFFF, 1'b1, 1'b0);

    send(1'b1, "99999999999");
    result("mnines", 32'h8000_0000, 1'b1, 1'b0);

    send(1'b0, "4<7");
    result("baddig", 32'd407, 1'b0, 1'b1);

    send(1'b0, "00000000000000000");
    result("long0", 32'd0, 1'b0, 1'b1);

    // 16 digits is the legal maximum; the 17th '9' must be dropped
    send(1'b0, "00000000000000129");
    result("long129", 32'd12, 1'b0, 1'b1);

    send(1'b0, "0000000000000012");
    result("max16", 32'd12, 1'b0, 1'b0);

    // Idle gap between beats holds the accumulator
    send(1'b0, "6");
    result("single6", 32'd6, 1'b0, 1'b0);
    in_valid = 1'b1; in_digit = 4'd6; in_last = 1'b0;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    chk("gap_valid", 32'(out_valid), 32'd0);
    chk("gap_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_digit = 4'd8; in_last = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    result("gap68", 32'd68, 1'b0, 1'b0);

    // Backpressure: result held for 5 cycles
    out_ready = 1'b0;
    send(1'b0, "77");
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", out_data, 32'd77);
      chk("hold_flags", {30'd0, out_ovf, out_err}, 32'd0);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("rel_valid", 32'(out_valid), 32'd0);
    chk("rel_ready", 32'(in_ready), 32'd1);
    send(1'b0, "5");
    result("after_hold", 32'd5, 1'b0, 1'b0);

    // clear after the 2nd digit of "987", colliding with the final beat
    send(1'b0, "98");
    clear = 1'b1;
    in_valid = 1'b1; in_digit = 4'd7; in_last = 1'b1;
    step();
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk("clr_valid", 32'(out_valid), 32'd0);
    chk("clr_ready", 32'(in_ready), 32'd1);
    step();
    chk("clr_valid2", 32'(out_valid), 32'd0);
    send(1'b0, "42");
    result("clr42", 32'd42, 1'b0, 1'b0);

    // clear while a result is waiting drops it
    out_ready = 1'b0;
    send(1'b0, "3");
    chk("pre_clr_valid", 32'(out_valid), 32'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    out_ready = 1'b1;
    chk("clr_done_valid", 32'(out_valid), 32'd0);
    chk("clr_done_data", out_data, 32'd0);

    // Reset after the 2nd digit of "987"
    send(1'b1, "98");
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_digit = 4'd7; in_last = 1'b1;
    step();
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_data", out_data, 32'd0);
    in_valid = 1'b0; in_last = 1'b0;
    rstn = 1'b1;
    step();
    chk("rst_mid_valid2", 32'(out_valid), 32'd0);
    chk("rst_rel_ready", 32'(in_ready), 32'd1);
    send(1'b0, "42");
    result("rst42", 32'd42, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
